// File: rtl/delay_axis_var.sv
// Runtime-variable sample delay for an NCHAN-wide AXI-Stream: inserts fill beats
// when the target delay grows, discards input when it shrinks, and bounds packet length.

module delay_axis_var_lane #(
   parameter int WIDTH = 16
) (
   input  logic             sel_pass,
   input  logic             sel_hold,
   input  logic [WIDTH-1:0] in_samp,
   input  logic [WIDTH-1:0] hold_samp,
   output logic [WIDTH-1:0] out_samp
);
   always_comb begin
      if (sel_pass)      out_samp = in_samp;
      else if (sel_hold) out_samp = hold_samp;
      else               out_samp = '0;
   end
endmodule

module delay_axis_var #(
   parameter int WIDTH        = 16,
   parameter int NCHAN        = 2,
   parameter int MAX_LEN_LOG2 = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic [MAX_LEN_LOG2-1:0]   len,
   input  logic [MAX_LEN_LOG2-1:0]   max_spp,
   input  logic                      fill_mode,
   input  logic [WIDTH*NCHAN-1:0]    i_tdata,
   input  logic                      i_tlast,
   input  logic                      i_tvalid,
   output logic                      i_tready,
   output logic [WIDTH*NCHAN-1:0]    o_tdata,
   output logic                      o_tlast,
   output logic                      o_tvalid,
   input  logic                      o_tready,
   output logic [MAX_LEN_LOG2-1:0]   cur_delay,
   output logic                      busy
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_INSERT = 2'd2;
   localparam logic [1:0] S_DROP   = 2'd3;
   localparam logic [MAX_LEN_LOG2-1:0] ONE = MAX_LEN_LOG2'(1);

   logic [1:0]                      state, next_state;
   logic [WIDTH*NCHAN-1:0]          last_sample;
   logic [MAX_LEN_LOG2-1:0]         out_cnt;
   logic [MAX_LEN_LOG2-1:0]         spp_m1;
   logic [MAX_LEN_LOG2:0]           delay_inc;
   logic                            force_last;
   logic                            sel_pass, sel_hold;
   logic                            i_hs, o_hs;

   assign spp_m1     = max_spp - ONE;
   // >= so that shrinking max_spp below the current count still closes the packet
   assign force_last = (max_spp != '0) && (out_cnt >= spp_m1);
   assign delay_inc  = {1'b0, cur_delay} + {{MAX_LEN_LOG2{1'b0}}, 1'b1};
   assign i_hs       = i_tvalid && i_tready;
   assign o_hs       = o_tvalid && o_tready;
   assign busy       = (state == S_INSERT) || (state == S_DROP);

   always_comb begin
      i_tready   = 1'b0;
      o_tvalid   = 1'b0;
      o_tlast    = 1'b0;
      sel_pass   = 1'b0;
      sel_hold   = 1'b0;
      next_state = state;
      case (state)
         S_IDLE: begin
            if (i_tvalid) next_state = (len != '0) ? S_INSERT : S_RUN;
         end
         S_RUN: begin
            o_tvalid = i_tvalid;
            i_tready = o_tready;
            o_tlast  = i_tlast | force_last;
            sel_pass = 1'b1;
            if (len > cur_delay)      next_state = S_INSERT;
            else if (len < cur_delay) next_state = S_DROP;
         end
         S_INSERT: begin
            o_tvalid = 1'b1;
            o_tlast  = force_last;
            sel_hold = !fill_mode;
            // leave only on a completed beat, so a pending beat is never retracted
            if (o_tready && (delay_inc >= {1'b0, len})) next_state = S_RUN;
         end
         default: begin
            i_tready = 1'b1;
            if (i_tvalid && ((cur_delay - ONE) <= len)) next_state = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state       <= S_IDLE;
         cur_delay   <= '0;
         out_cnt     <= '0;
         last_sample <= '0;
      end else begin
         state <= next_state;
         if ((state == S_IDLE && i_tvalid) || i_hs) last_sample <= i_tdata;
         if (state == S_INSERT && o_hs)    cur_delay <= cur_delay + ONE;
         else if (state == S_DROP && i_hs) cur_delay <= cur_delay - ONE;
         if (o_hs) out_cnt <= o_tlast ? '0 : out_cnt + ONE;
      end
   end

   logic [NCHAN-1:0][WIDTH-1:0] in_lanes, hold_lanes, out_lanes;
   assign in_lanes   = i_tdata;
   assign hold_lanes = last_sample;
   assign o_tdata    = out_lanes;

   genvar ch;
   generate
      for (ch = 0; ch < NCHAN; ch++) begin : g_lane
         delay_axis_var_lane #(.WIDTH(WIDTH)) u_lane (
            .sel_pass  (sel_pass),
            .sel_hold  (sel_hold),
            .in_samp   (in_lanes[ch]),
            .hold_samp (hold_lanes[ch]),
            .out_samp  (out_lanes[ch])
         );
      end
   endgenerate
endmodule

// File: doc/delay_axis_var.md
# delay_axis_var

Runtime-variable sample delay for the GMRR AXI-Stream datapath, carrying NCHAN parallel channels packed in one tdata word. It inserts fill samples when the programmed delay grows and discards input samples when it shrinks. It regenerates packet boundaries with a max-samples-per-packet counter, so output packets stay bounded during insert and drop events. It sits inline between the sample source and the framer, and its delay target comes from a settings register.

## Interface
- WIDTH, 16, bits per channel sample
- NCHAN, 2, channels packed in tdata (channel 0 in the LSBs); all channels get the same delay
- MAX_LEN_LOG2, 10, width of delay and SPP quantities
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous, active-high; same effect as reset
- len  in  MAX_LEN_LOG2  target delay in samples
- max_spp  in  MAX_LEN_LOG2  forced-tlast period; 0 disables forced tlast
- fill_mode  in  1  0 = repeat last sample, 1 = insert zeros
- i_tdata  in  WIDTH*NCHAN;  i_tlast, i_tvalid  in  1;  i_tready  out  1
- o_tdata  out  WIDTH*NCHAN;  o_tlast, o_tvalid  out  1;  o_tready  in  1
- cur_delay  out  MAX_LEN_LOG2  currently applied delay
- busy  out  1  high in INSERT or DROP

## Operation
- Registers:
  - state: IDLE, RUN, INSERT or DROP.
  - cur_delay: unsigned, with range 0..2^MAX_LEN_LOG2-1. It never wraps, because len has the same width.
  - last_sample.
  - out_cnt: width MAX_LEN_LOG2.
- IDLE:
  - Outputs: i_tready=0, o_tvalid=0.
  - When i_tvalid=1, load last_sample with i_tdata as a peek (nothing is consumed).
  - Next state is INSERT if len>0, else RUN.
- RUN: combinational passthrough.
  - Outputs: o_tvalid=i_tvalid, i_tready=o_tready, o_tdata=i_tdata.
  - On each handshake, last_sample<=i_tdata.
  - At each edge, go to INSERT if len>cur_delay, to DROP if len<cur_delay, else stay in RUN.
- INSERT: produces without consuming.
  - Outputs: i_tready=0, o_tvalid=1.
  - o_tdata is {NCHAN{0}} when fill_mode=1, else last_sample. fill_mode is sampled each beat.
  - o_tvalid stays high until the handshake.
  - On each o handshake, cur_delay++. If cur_delay+1>=len, go to RUN.
  - If len drops mid-INSERT, the pending beat still completes; DROP is reached through RUN.
- DROP: consumes without producing.
  - Outputs: i_tready=1, o_tvalid=0.
  - On each i handshake: cur_delay--, last_sample<=i_tdata, and i_tlast is discarded. If cur_delay-1<=len, go to RUN.
- tlast generation:
  - force = (max_spp!=0) && (out_cnt==max_spp-1).
  - RUN: o_tlast = i_tlast | force.
  - INSERT: o_tlast = force.
  - IDLE/DROP: o_tlast = 0.
  - On each o handshake, out_cnt is set to 0 if o_tlast, else incremented.
  - Changing max_spp mid-packet: if out_cnt>=max_spp-1 already, tlast is forced on the next beat.
- busy = state is INSERT or DROP.
- Reset/clear, applied mid-operation at any point:
  - state=IDLE; cur_delay, out_cnt and last_sample = 0.
  - Resulting outputs: o_tvalid=0, i_tready=0, o_tlast=0, busy=0, cur_delay=0, o_tdata=0.
  - A beat in flight is abandoned without a handshake.

## Timing
- RUN has a data latency of 0 cycles (no register in the data path).
- A len change is acted on at the first edge after it is seen in RUN. A handshake occurring in that cycle completes in RUN.
- INSERT/DROP throughput is 1 beat per cycle while the partner is ready.
- Re-entry into RUN costs 0 idle cycles. The next RUN cycle may pass data immediately.
- Worst-case delay convergence is |len-cur_delay| beats of the relevant handshake plus 1 cycle.
- All outputs are combinational from state, registers and the stream inputs. There is no combinational path from o_tready to o_tvalid.

## Test plan
- Passthrough:
  - Stimulus: reset; len=0, max_spp=0; 8 beats 1..8 with tlast on beat 8; o_tready=1.
  - Required: identical output with 0 latency; cur_delay=0; busy=0.
- Startup insert with hold:
  - Stimulus: len=3, fill_mode=0, input 0x11,0x22,...
  - Required: output 0x11,0x11,0x11,0x11,0x22,...; cur_delay=3; busy high for exactly the 3 insert beats.
- Zero fill and backpressure:
  - Stimulus: in RUN at cur_delay=0, set len=2 with fill_mode=1; hold o_tready low for 4 cycles.
  - Required: o_tvalid stays high with o_tdata=0 and is not dropped; exactly 2 zero beats, then passthrough.
- Drop:
  - Stimulus: cur_delay=5, set len=1; input 100..110.
  - Required: 4 input beats consumed with o_tvalid=0; the next output is the 5th input beat; cur_delay=1.
- Forced tlast:
  - Stimulus: max_spp=4, len raised from 0 to 6 mid-stream, input without tlast.
  - Required: o_tlast on every 4th output beat, including on insert beats.
- Reset mid-INSERT:
  - Stimulus: assert clear while in INSERT with cur_delay=2.
  - Required: next cycle state=IDLE, o_tvalid=0, cur_delay=0, busy=0. On the next i_tvalid with len=2, 2 fill beats are inserted again.
